// File: rtl/pdu_pkg.sv
// Shared encodings for the processor debug unit: run states, display modes,
// IO register addresses and the active-low hex-to-7-segment font.
package pdu_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2
  } run_state_e;

  typedef enum logic [1:0] {
    DM_SEG = 2'd0,
    DM_PC  = 2'd1,
    DM_RF  = 2'd2,
    DM_DM  = 2'd3
  } disp_mode_e;

  localparam int IO_LED    = 'h00;
  localparam int IO_SEG    = 'h04;
  localparam int IO_STATUS = 'h08;
  localparam int IO_SWDATA = 'h0C;
  localparam int IO_BP     = 'h10;
  localparam int IO_BPEN   = 'h14;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] r_code;
    case (nib)
      4'h0:    r_code = 7'h40;
      4'h1:    r_code = 7'h79;
      4'h2:    r_code = 7'h24;
      4'h3:    r_code = 7'h30;
      4'h4:    r_code = 7'h19;
      4'h5:    r_code = 7'h12;
      4'h6:    r_code = 7'h02;
      4'h7:    r_code = 7'h78;
      4'h8:    r_code = 7'h00;
      4'h9:    r_code = 7'h10;
      4'hA:    r_code = 7'h08;
      4'hB:    r_code = 7'h03;
      4'hC:    r_code = 7'h46;
      4'hD:    r_code = 7'h21;
      4'hE:    r_code = 7'h06;
      default: r_code = 7'h0E;
    endcase
    return r_code;
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Button conditioner: synchronises a raw button, accepts a new level only after
// DB_CYCLES stable cycles, and emits a single-cycle pulse when that level is 1.
module btn_pulse #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES);

  logic          r_meta;
  logic          r_sync;
  logic          r_cand;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_cand  <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      o_pulse <= 1'b0;
    end else begin
      r_meta  <= i_btn;
      r_sync  <= r_meta;
      o_pulse <= 1'b0;
      // Any change of the sampled level restarts the stability count.
      if (r_sync != r_cand) begin
        r_cand <= r_sync;
        r_cnt  <= CW'(1);
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_cnt == CNT_MAX && r_level != r_cand) begin
        r_level <= r_cand;
        o_pulse <= r_cand;
      end
    end
  end

endmodule

// File: rtl/pdu_ctl_gen.sv
// Parametrised processor debug unit: run control, debounced buttons, IO
// register file and 7-segment scanning. Define PDU_BREAKPOINT_EN for the breakpoint.
module pdu_ctl_gen
  import pdu_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 8,
  parameter int SW_W      = 16,
  parameter int LED_W     = 16,
  parameter int DIGITS    = 8,
  parameter int DB_CYCLES = 1000000,
  parameter int SCAN_DIV  = 100000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              step,
  input  logic              cont,
  input  logic              chk,
  input  logic              ent,
  input  logic [SW_W-1:0]   hd,
  output logic              cpu_en,
  output logic              pause,
  output logic [LED_W-1:0]  led,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        seg,
  input  logic [AW-1:0]     io_addr,
  input  logic [DW-1:0]     io_dout,
  input  logic              io_we,
  input  logic              io_rd,
  output logic [DW-1:0]     io_din,
  output logic [AW-1:0]     dbg_addr,
  input  logic [DW-1:0]     pc,
  input  logic [DW-1:0]     rf_data,
  input  logic [DW-1:0]     dm_data
);

  localparam int SCW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DGW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NIBS = DW / 4;

  logic w_step_p, w_cont_p, w_chk_p, w_ent_p;

  btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_btn_step (.clk(clk), .rstn(rstn), .i_btn(step), .o_pulse(w_step_p));
  btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_btn_cont (.clk(clk), .rstn(rstn), .i_btn(cont), .o_pulse(w_cont_p));
  btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_btn_chk  (.clk(clk), .rstn(rstn), .i_btn(chk),  .o_pulse(w_chk_p));
  btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_btn_ent  (.clk(clk), .rstn(rstn), .i_btn(ent),  .o_pulse(w_ent_p));

  run_state_e       r_state, w_state_nxt;
  disp_mode_e       r_mode, w_mode_nxt;
  logic             w_cpu_en, w_pause, w_bp_hit, w_wr, w_rd;
  logic [LED_W-1:0] r_led;
  logic [DW-1:0]    r_seg_reg;
  logic [SW_W-1:0]  r_sw_buf;
  logic             r_sw_valid;
  logic [DW-1:0]    w_rdata;

`ifdef PDU_BREAKPOINT_EN
  logic [DW-1:0] r_bp;
  logic          r_bp_en;

  // A hit parks the core in the same cycle, so the matching instruction never executes.
  assign w_bp_hit = (r_state == ST_RUN) && r_bp_en && (pc == r_bp);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bp    <= '0;
      r_bp_en <= 1'b0;
    end else begin
      if (w_wr && io_addr == AW'(IO_BP))   r_bp    <= io_dout;
      if (w_wr && io_addr == AW'(IO_BPEN)) r_bp_en <= io_dout[0];
    end
  end
`else
  assign w_bp_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_PAUSE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cpu_en    = 1'b0;
    w_pause     = 1'b1;
    unique case (r_state)
      ST_PAUSE: begin
        if (w_cont_p)      w_state_nxt = ST_RUN;
        else if (w_step_p) w_state_nxt = ST_STEP;
      end
      ST_RUN: begin
        w_cpu_en = !w_bp_hit;
        w_pause  = w_bp_hit;
        if (w_bp_hit || w_cont_p) w_state_nxt = ST_PAUSE;
      end
      ST_STEP: begin
        w_cpu_en    = 1'b1;
        w_state_nxt = ST_PAUSE;
      end
      default: w_state_nxt = ST_PAUSE;
    endcase
  end

  assign cpu_en   = w_cpu_en;
  assign pause    = w_pause;
  assign w_wr     = io_we && w_cpu_en;
  assign w_rd     = io_rd && w_cpu_en;
  assign led      = r_led;
  assign dbg_addr = AW'(hd);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_led      <= '0;
      r_seg_reg  <= '0;
      r_sw_buf   <= '0;
      r_sw_valid <= 1'b0;
    end else begin
      if (w_wr && io_addr == AW'(IO_LED)) r_led     <= io_dout[LED_W-1:0];
      if (w_wr && io_addr == AW'(IO_SEG)) r_seg_reg <= io_dout;
      // A commit in the same cycle as the consuming read keeps the new data valid.
      if (w_ent_p) begin
        r_sw_buf   <= hd;
        r_sw_valid <= 1'b1;
      end else if (w_rd && io_addr == AW'(IO_SWDATA)) begin
        r_sw_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (io_addr == AW'(IO_LED))         w_rdata = DW'(r_led);
    else if (io_addr == AW'(IO_SEG))    w_rdata = r_seg_reg;
    else if (io_addr == AW'(IO_STATUS)) w_rdata = DW'(r_sw_valid);
    else if (io_addr == AW'(IO_SWDATA)) w_rdata = DW'(r_sw_buf);
`ifdef PDU_BREAKPOINT_EN
    else if (io_addr == AW'(IO_BP))     w_rdata = r_bp;
    else if (io_addr == AW'(IO_BPEN))   w_rdata = DW'(r_bp_en);
`endif
  end

  assign io_din = w_rdata;

  always_comb begin
    unique case (r_mode)
      DM_SEG:  w_mode_nxt = DM_PC;
      DM_PC:   w_mode_nxt = DM_RF;
      DM_RF:   w_mode_nxt = DM_DM;
      default: w_mode_nxt = DM_SEG;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        r_mode <= DM_SEG;
    else if (w_chk_p) r_mode <= w_pause ? w_mode_nxt : DM_SEG;
  end

  logic [SCW-1:0]    r_scan_cnt;
  logic [DGW-1:0]    r_digit;
  logic [DIGITS-1:0] r_an;
  logic [7:0]        r_seg;
  logic [DW-1:0]     w_shown;
  logic [3:0]        w_nib;
  logic              w_blank;

  always_comb begin
    unique case (r_mode)
      DM_SEG:  w_shown = r_seg_reg;
      DM_PC:   w_shown = pc;
      DM_RF:   w_shown = rf_data;
      default: w_shown = dm_data;
    endcase
  end

  assign w_nib   = 4'(w_shown >> {r_digit, 2'b00});
  assign w_blank = (int'(r_digit) >= NIBS);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_scan_cnt <= '0;
      r_digit    <= '0;
      r_an       <= '1;
      r_seg      <= 8'hFF;
    end else begin
      if (r_scan_cnt == SCW'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_digit    <= (r_digit == DGW'(DIGITS - 1)) ? '0 : r_digit + DGW'(1);
      end else begin
        r_scan_cnt <= r_scan_cnt + SCW'(1);
      end
      r_an  <= ~(DIGITS'(1) << r_digit);
      r_seg <= w_blank ? 8'hFF : {1'b1, hex7seg(w_nib)};
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule
